// File: rtl/punc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : punc_control                                                 |
// | Description : Multicycle control FSM for the PUnC LC3 processor. Decodes   |
// |               the instruction register and condition codes into every      |
// |               datapath select and strobe; counts retired instructions.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module punc_control #(
  parameter int HALT_ON_RSVD = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic [2:0]       cond,
  output logic             d_w_en,
  output logic [1:0]       d_r_addr_sel,
  output logic [1:0]       d_w_addr_sel,
  output logic             rf_w_en,
  output logic [1:0]       rf_r_addr_0_sel,
  output logic [1:0]       rf_r_addr_1_sel,
  output logic             rf_w_addr_sel,
  output logic [1:0]       rf_w_data_sel,
  output logic             ir_ld,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             temp_ld,
  output logic             status_w_en,
  output logic             alu_in_0_sel,
  output logic [2:0]       alu_in_1_sel,
  output logic [1:0]       alu_sel,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] c_S_FETCH  = 3'd0;
  localparam logic [2:0] c_S_DECODE = 3'd1;
  localparam logic [2:0] c_S_EXEC   = 3'd2;
  localparam logic [2:0] c_S_EXEC2  = 3'd3;
  localparam logic [2:0] c_S_HALT   = 3'd4;

  localparam logic [3:0] c_OP_BR   = 4'b0000;
  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_LD   = 4'b0010;
  localparam logic [3:0] c_OP_ST   = 4'b0011;
  localparam logic [3:0] c_OP_JSR  = 4'b0100;
  localparam logic [3:0] c_OP_AND  = 4'b0101;
  localparam logic [3:0] c_OP_LDR  = 4'b0110;
  localparam logic [3:0] c_OP_STR  = 4'b0111;
  localparam logic [3:0] c_OP_RTI  = 4'b1000;
  localparam logic [3:0] c_OP_NOT  = 4'b1001;
  localparam logic [3:0] c_OP_LDI  = 4'b1010;
  localparam logic [3:0] c_OP_STI  = 4'b1011;
  localparam logic [3:0] c_OP_JMP  = 4'b1100;
  localparam logic [3:0] c_OP_RSVD = 4'b1101;
  localparam logic [3:0] c_OP_LEA  = 4'b1110;
  localparam logic [3:0] c_OP_HALT = 4'b1111;

  localparam logic [1:0] c_MADDR_ALU  = 2'd1;
  localparam logic [1:0] c_MADDR_TEMP = 2'd2;
  localparam logic [1:0] c_R0_BASE    = 2'd2;
  localparam logic [1:0] c_R1_SR2     = 2'd1;
  localparam logic [1:0] c_R1_SR      = 2'd2;
  localparam logic       c_WADDR_R7   = 1'b1;
  localparam logic [1:0] c_WDATA_MEM  = 2'd1;
  localparam logic [1:0] c_WDATA_PC   = 2'd2;
  localparam logic       c_IN0_PC     = 1'b1;
  localparam logic [2:0] c_IN1_IMM5   = 3'd0;
  localparam logic [2:0] c_IN1_OFF6   = 3'd1;
  localparam logic [2:0] c_IN1_PCOFF9 = 3'd2;
  localparam logic [2:0] c_IN1_PCOFF11= 3'd3;
  localparam logic [2:0] c_IN1_RF1    = 3'd4;
  localparam logic [1:0] c_ALU_ADD    = 2'd0;
  localparam logic [1:0] c_ALU_AND    = 2'd1;
  localparam logic [1:0] c_ALU_NOT    = 2'd2;
  localparam logic [1:0] c_ALU_PASS   = 2'd3;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       w_op;
  logic             w_taken, w_two_phase, w_stops, w_retire;
  logic             w_unused_ir;

  assign w_op        = ir[15:12];
  // cond is {N,Z,P}, lining up bit-for-bit with the n/z/p flags in ir[11:9]
  assign w_taken     = |(ir[11:9] & cond);
  assign w_two_phase = (w_op == c_OP_LDI) || (w_op == c_OP_STI);
  assign w_stops     = (w_op == c_OP_HALT) ||
                       ((HALT_ON_RSVD != 0) && ((w_op == c_OP_RTI) || (w_op == c_OP_RSVD)));
  assign w_retire    = ((state_q == c_S_EXEC) && !w_two_phase) || (state_q == c_S_EXEC2);
  assign w_unused_ir = ^{ir[8:6], ir[4:0]};

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state sequencing and counter increment on each instruction's final cycle
  always_comb begin
    state_d = c_S_FETCH;
    count_d = w_retire ? count_q + 1'b1 : count_q;
    case (state_q)
      c_S_FETCH:  state_d = c_S_DECODE;
      c_S_DECODE: state_d = c_S_EXEC;
      c_S_EXEC: begin
        if (w_two_phase)  state_d = c_S_EXEC2;
        else if (w_stops) state_d = c_S_HALT;
        else              state_d = c_S_FETCH;
      end
      c_S_EXEC2:  state_d = c_S_FETCH;
      c_S_HALT:   state_d = c_S_HALT;
      default:    state_d = c_S_FETCH;
    endcase
  end

  // Datapath controls; everything is forced low while reset is asserted
  always_comb begin
    d_w_en = 1'b0; d_r_addr_sel = 2'd0; d_w_addr_sel = 2'd0;
    rf_w_en = 1'b0; rf_r_addr_0_sel = 2'd0; rf_r_addr_1_sel = 2'd0;
    rf_w_addr_sel = 1'b0; rf_w_data_sel = 2'd0;
    ir_ld = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0; temp_ld = 1'b0; status_w_en = 1'b0;
    alu_in_0_sel = 1'b0; alu_in_1_sel = 3'd0; alu_sel = 2'd0;
    if (rst) begin
      case (state_q)
        c_S_FETCH: begin
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
        c_S_EXEC: begin
          case (w_op)
            c_OP_ADD, c_OP_AND: begin
              alu_sel = (w_op == c_OP_AND) ? c_ALU_AND : c_ALU_ADD;
              if (ir[5]) begin
                alu_in_1_sel = c_IN1_IMM5;
              end else begin
                alu_in_1_sel    = c_IN1_RF1;
                rf_r_addr_1_sel = c_R1_SR2;
              end
              rf_w_en = 1'b1; status_w_en = 1'b1;
            end
            c_OP_NOT: begin
              alu_sel = c_ALU_NOT; rf_w_en = 1'b1; status_w_en = 1'b1;
            end
            c_OP_BR: begin
              alu_in_0_sel = c_IN0_PC; alu_in_1_sel = c_IN1_PCOFF9; pc_ld = w_taken;
            end
            c_OP_JMP: begin
              rf_r_addr_0_sel = c_R0_BASE; alu_sel = c_ALU_PASS; pc_ld = 1'b1;
            end
            c_OP_JSR: begin
              // R7 captures the already-incremented PC on the same edge the PC reloads
              rf_w_en = 1'b1; rf_w_addr_sel = c_WADDR_R7; rf_w_data_sel = c_WDATA_PC; pc_ld = 1'b1;
              if (ir[11]) begin
                alu_in_0_sel = c_IN0_PC; alu_in_1_sel = c_IN1_PCOFF11;
              end else begin
                rf_r_addr_0_sel = c_R0_BASE; alu_sel = c_ALU_PASS;
              end
            end
            c_OP_LD, c_OP_LEA: begin
              alu_in_0_sel = c_IN0_PC; alu_in_1_sel = c_IN1_PCOFF9;
              rf_w_en = 1'b1; status_w_en = 1'b1;
              if (w_op == c_OP_LD) begin
                d_r_addr_sel = c_MADDR_ALU; rf_w_data_sel = c_WDATA_MEM;
              end
            end
            c_OP_LDR: begin
              rf_r_addr_0_sel = c_R0_BASE; alu_in_1_sel = c_IN1_OFF6;
              d_r_addr_sel = c_MADDR_ALU; rf_w_en = 1'b1; rf_w_data_sel = c_WDATA_MEM;
              status_w_en = 1'b1;
            end
            c_OP_ST: begin
              alu_in_0_sel = c_IN0_PC; alu_in_1_sel = c_IN1_PCOFF9;
              d_w_addr_sel = c_MADDR_ALU; rf_r_addr_1_sel = c_R1_SR; d_w_en = 1'b1;
            end
            c_OP_STR: begin
              rf_r_addr_0_sel = c_R0_BASE; alu_in_1_sel = c_IN1_OFF6;
              d_w_addr_sel = c_MADDR_ALU; rf_r_addr_1_sel = c_R1_SR; d_w_en = 1'b1;
            end
            c_OP_LDI, c_OP_STI: begin
              // First hop: fetch the pointer word into TEMP
              alu_in_0_sel = c_IN0_PC; alu_in_1_sel = c_IN1_PCOFF9;
              d_r_addr_sel = c_MADDR_ALU; temp_ld = 1'b1;
            end
            default: ;
          endcase
        end
        c_S_EXEC2: begin
          if (w_op == c_OP_STI) begin
            d_w_addr_sel = c_MADDR_TEMP; rf_r_addr_1_sel = c_R1_SR; d_w_en = 1'b1;
          end else begin
            d_r_addr_sel = c_MADDR_TEMP; rf_w_en = 1'b1; rf_w_data_sel = c_WDATA_MEM;
            status_w_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted      = (state_q == c_S_HALT);
  assign instr_count = count_q;
  assign state_dbg   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_punc_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_punc_control                                              |
// | Description : Self-checking bench for punc_control: directed scenarios     |
// |               plus random instructions against a rule-based control model. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_punc_control;

  typedef struct packed {
    logic       d_w_en;
    logic [1:0] d_r_addr_sel;
    logic [1:0] d_w_addr_sel;
    logic       rf_w_en;
    logic [1:0] rf_r0;
    logic [1:0] rf_r1;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_inc;
    logic       temp_ld;
    logic       status_w_en;
    logic       alu_in_0_sel;
    logic [2:0] alu_in_1_sel;
    logic [1:0] alu_sel;
    logic       halted;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir = 16'h0;
  logic [2:0]  cond = 3'b0;

  int n_vec = 0;
  int n_err = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  // Instance A: default parameters. Instance B: 2-bit counter, reserved opcodes act as NOP.
  logic a_dwe, a_rfwe, a_rfwa, a_irld, a_pcld, a_pcinc, a_tmp, a_st, a_in0, a_halt;
  logic [1:0] a_dra, a_dwa, a_r0, a_r1, a_wd, a_alu;
  logic [2:0] a_in1, a_state;
  logic [15:0] a_cnt;
  logic b_dwe, b_rfwe, b_rfwa, b_irld, b_pcld, b_pcinc, b_tmp, b_st, b_in0, b_halt;
  logic [1:0] b_dra, b_dwa, b_r0, b_r1, b_wd, b_alu;
  logic [2:0] b_in1, b_state;
  logic [1:0] b_cnt;
  ctl_t a_c, b_c;

  assign a_c = {a_dwe, a_dra, a_dwa, a_rfwe, a_r0, a_r1, a_rfwa, a_wd, a_irld, a_pcld,
                a_pcinc, a_tmp, a_st, a_in0, a_in1, a_alu, a_halt};
  assign b_c = {b_dwe, b_dra, b_dwa, b_rfwe, b_r0, b_r1, b_rfwa, b_wd, b_irld, b_pcld,
                b_pcinc, b_tmp, b_st, b_in0, b_in1, b_alu, b_halt};

  punc_control dut_a (
    .clk(clk), .rst(rst), .ir(ir), .cond(cond),
    .d_w_en(a_dwe), .d_r_addr_sel(a_dra), .d_w_addr_sel(a_dwa), .rf_w_en(a_rfwe),
    .rf_r_addr_0_sel(a_r0), .rf_r_addr_1_sel(a_r1), .rf_w_addr_sel(a_rfwa),
    .rf_w_data_sel(a_wd), .ir_ld(a_irld), .pc_ld(a_pcld), .pc_inc(a_pcinc),
    .temp_ld(a_tmp), .status_w_en(a_st), .alu_in_0_sel(a_in0), .alu_in_1_sel(a_in1),
    .alu_sel(a_alu), .halted(a_halt), .instr_count(a_cnt), .state_dbg(a_state)
  );

  punc_control #(.HALT_ON_RSVD(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .ir(ir), .cond(cond),
    .d_w_en(b_dwe), .d_r_addr_sel(b_dra), .d_w_addr_sel(b_dwa), .rf_w_en(b_rfwe),
    .rf_r_addr_0_sel(b_r0), .rf_r_addr_1_sel(b_r1), .rf_w_addr_sel(b_rfwa),
    .rf_w_data_sel(b_wd), .ir_ld(b_irld), .pc_ld(b_pcld), .pc_inc(b_pcinc),
    .temp_ld(b_tmp), .status_w_en(b_st), .alu_in_0_sel(b_in0), .alu_in_1_sel(b_in1),
    .alu_sel(b_alu), .halted(b_halt), .instr_count(b_cnt), .state_dbg(b_state)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic logic [6:0] strobes(input ctl_t c);
    return {c.d_w_en, c.rf_w_en, c.ir_ld, c.pc_ld, c.pc_inc, c.temp_ld, c.status_w_en};
  endfunction

  // Expected controls for one cycle. ph: 0 fetch, 1 decode, 2 execute, 3 second execute, 4 halted.
  // Written role by role: where the address comes from, what the register file receives, which strobes fire.
  function automatic ctl_t model(input logic [15:0] i, input logic [2:0] c, input int ph);
    ctl_t e;
    int op;
    bit pc9, base6, load_mem, writes_dr;
    e = '0;
    op = int'(i[15:12]);
    if (ph == 0) begin
      e.ir_ld = 1'b1; e.pc_inc = 1'b1;
    end else if (ph == 4) begin
      e.halted = 1'b1;
    end else if (ph == 3) begin
      if (op == 11) begin e.d_w_addr_sel = 2; e.rf_r1 = 2; e.d_w_en = 1'b1; end
      else begin e.d_r_addr_sel = 2; e.rf_w_en = 1'b1; e.rf_w_data_sel = 1; e.status_w_en = 1'b1; end
    end else if (ph == 2) begin
      pc9       = (op == 0) || (op == 2) || (op == 3) || (op == 10) || (op == 11) || (op == 14);
      base6     = (op == 6) || (op == 7);
      load_mem  = (op == 2) || (op == 6);
      writes_dr = (op == 1) || (op == 5) || (op == 9) || load_mem || (op == 14);
      if (pc9)   begin e.alu_in_0_sel = 1'b1; e.alu_in_1_sel = 2; end
      if (base6) begin e.rf_r0 = 2; e.alu_in_1_sel = 1; end
      if (writes_dr) begin e.rf_w_en = 1'b1; e.status_w_en = 1'b1; end
      if (load_mem) begin e.d_r_addr_sel = 1; e.rf_w_data_sel = 1; end
      if (op == 3 || op == 7) begin e.d_w_addr_sel = 1; e.rf_r1 = 2; e.d_w_en = 1'b1; end
      if (op == 10 || op == 11) begin e.d_r_addr_sel = 1; e.temp_ld = 1'b1; end
      if (op == 1 || op == 5) begin
        e.alu_sel = (op == 5) ? 2'd1 : 2'd0;
        if (!i[5]) begin e.alu_in_1_sel = 4; e.rf_r1 = 1; end
      end
      if (op == 9) e.alu_sel = 2;
      if (op == 0) e.pc_ld = ((i[11] && c[2]) || (i[10] && c[1]) || (i[9] && c[0]));
      if (op == 12) begin e.rf_r0 = 2; e.alu_sel = 3; e.pc_ld = 1'b1; end
      if (op == 4) begin
        e.rf_w_en = 1'b1; e.rf_w_addr_sel = 1'b1; e.rf_w_data_sel = 2; e.pc_ld = 1'b1;
        if (i[11]) begin e.alu_in_0_sel = 1'b1; e.alu_in_1_sel = 3; end
        else begin e.rf_r0 = 2; e.alu_sel = 3; end
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ir = 16'h1261;
    #3;
    n_vec++; if (a_state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", a_state); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    n_vec++; if (a_halt !== 1'b0) begin n_err++; $display("FAIL reset_halted got %0b exp 0", a_halt); end
    n_vec++; if (strobes(a_c) !== 7'd0) begin n_err++; $display("FAIL reset_strobes got %b exp 0000000", strobes(a_c)); end
    n_vec++; if (b_cnt !== 2'd0) begin n_err++; $display("FAIL reset_count_b got %0d exp 0", b_cnt); end
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    ir = 16'h1261; cond = 3'b010;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (a_state !== 3'(k)) begin n_err++; $display("FAIL add_state got %0d exp %0d", a_state, k); end
      if (k == 2) begin
        n_vec++; if (a_in1 !== 3'd0) begin n_err++; $display("FAIL add_in1 got %0d exp 0", a_in1); end
        n_vec++; if (a_rfwe !== 1'b1) begin n_err++; $display("FAIL add_rfwe got %0b exp 1", a_rfwe); end
        n_vec++; if (a_st !== 1'b1) begin n_err++; $display("FAIL add_status got %0b exp 1", a_st); end
      end
      tick();
    end
    n_vec++; if (a_state !== 3'd0) begin n_err++; $display("FAIL add_back_fetch got %0d exp 0", a_state); end
    n_vec++; if (a_cnt !== 16'd1) begin n_err++; $display("FAIL add_count got %0d exp 1", a_cnt); end
  endtask

  task automatic test_br();
    do_reset();
    ir = 16'h0402; cond = 3'b010;
    tick(); tick();
    n_vec++; if (a_pcld !== 1'b1) begin n_err++; $display("FAIL br_taken_pcld got %0b exp 1", a_pcld); end
    n_vec++; if (a_in0 !== 1'b1) begin n_err++; $display("FAIL br_in0 got %0b exp 1", a_in0); end
    n_vec++; if (a_in1 !== 3'd2) begin n_err++; $display("FAIL br_in1 got %0d exp 2", a_in1); end
    n_vec++; if (a_pcinc !== 1'b0) begin n_err++; $display("FAIL br_pcinc got %0b exp 0", a_pcinc); end
    tick();
    cond = 3'b001;
    tick(); tick();
    n_vec++; if (a_pcld !== 1'b0) begin n_err++; $display("FAIL br_nottaken_pcld got %0b exp 0", a_pcld); end
    tick();
  endtask

  task automatic test_ldi();
    do_reset();
    ir = 16'hA205; cond = 3'b100;
    tick(); tick();
    n_vec++; if (a_tmp !== 1'b1) begin n_err++; $display("FAIL ldi_temp_ld got %0b exp 1", a_tmp); end
    n_vec++; if (a_dra !== 2'd1) begin n_err++; $display("FAIL ldi_exec_raddr got %0d exp 1", a_dra); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL ldi_early_count got %0d exp 0", a_cnt); end
    tick();
    n_vec++; if (a_state !== 3'd3) begin n_err++; $display("FAIL ldi_exec2_state got %0d exp 3", a_state); end
    n_vec++; if (a_dra !== 2'd2) begin n_err++; $display("FAIL ldi_exec2_raddr got %0d exp 2", a_dra); end
    n_vec++; if (a_wd !== 2'd1) begin n_err++; $display("FAIL ldi_wdata got %0d exp 1", a_wd); end
    tick();
    n_vec++; if (a_state !== 3'd0 || a_cnt !== 16'd1) begin n_err++;
      $display("FAIL ldi_done got state %0d count %0d exp state 0 count 1", a_state, a_cnt); end
  endtask

  task automatic test_jsr();
    do_reset();
    ir = 16'h4FFE;
    tick(); tick();
    n_vec++; if (a_rfwa !== 1'b1) begin n_err++; $display("FAIL jsr_waddr got %0b exp 1", a_rfwa); end
    n_vec++; if (a_wd !== 2'd2) begin n_err++; $display("FAIL jsr_wdata got %0d exp 2", a_wd); end
    n_vec++; if (a_rfwe !== 1'b1 || a_pcld !== 1'b1) begin n_err++;
      $display("FAIL jsr_strobes got rfwe %0b pcld %0b exp 1 1", a_rfwe, a_pcld); end
    n_vec++; if (a_in1 !== 3'd3) begin n_err++; $display("FAIL jsr_in1 got %0d exp 3", a_in1); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
    int len;
    ctl_t e;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      ir   = {ops[$urandom_range(0, 12)], 12'($urandom)};
      cond = 3'($urandom);
      len  = (ir[15:12] == 4'hA || ir[15:12] == 4'hB) ? 4 : 3;
      #1;
      for (int ph = 0; ph < len; ph++) begin
        e = model(ir, cond, ph);
        n_vec++; if (a_c !== e || a_state !== 3'(ph) || a_cnt !== cnt_a[15:0]) begin n_err++;
          $display("FAIL rand_a ir %h ph %0d got ctl %h st %0d cnt %0d exp ctl %h st %0d cnt %0d",
                   ir, ph, a_c, a_state, a_cnt, e, ph, cnt_a[15:0]); end
        n_vec++; if (b_c !== e || b_cnt !== cnt_b[1:0]) begin n_err++;
          $display("FAIL rand_b ir %h ph %0d got ctl %h cnt %0d exp ctl %h cnt %0d",
                   ir, ph, b_c, b_cnt, e, cnt_b[1:0]); end
        tick();
      end
      cnt_a++; cnt_b++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir = 16'h1261;
    tick(); tick(); tick();
    ir = 16'h5262;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    n_vec++; if (a_state !== 3'd0) begin n_err++; $display("FAIL midrst_state got %0d exp 0", a_state); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_count got %0d exp 0", a_cnt); end
    n_vec++; if (strobes(a_c) !== 7'd0) begin n_err++; $display("FAIL midrst_strobes got %b exp 0000000", strobes(a_c)); end
    @(posedge clk); #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    ir = 16'h1261;
    for (int n = 0; n < 5; n++) begin
      tick(); tick(); tick();
      n_vec++; if (b_cnt !== exp_b[n]) begin n_err++; $display("FAIL wrap_count_b got %0d exp %0d", b_cnt, exp_b[n]); end
      n_vec++; if (a_cnt !== 16'(n + 1)) begin n_err++; $display("FAIL wrap_count_a got %0d exp %0d", a_cnt, n + 1); end
    end
  endtask

  task automatic test_rsvd();
    do_reset();
    ir = 16'hD000;
    tick(); tick(); tick();
    n_vec++; if (b_state !== 3'd0 || b_halt !== 1'b0 || b_cnt !== 2'd1) begin n_err++;
      $display("FAIL rsvd_nop got state %0d halted %0b cnt %0d exp 0 0 1", b_state, b_halt, b_cnt); end
    n_vec++; if (a_state !== 3'd4 || a_halt !== 1'b1 || a_cnt !== 16'd1) begin n_err++;
      $display("FAIL rsvd_halt got state %0d halted %0b cnt %0d exp 4 1 1", a_state, a_halt, a_cnt); end
    ir = 16'h8000;
    tick(); tick(); tick();
    n_vec++; if (b_state !== 3'd0 || b_cnt !== 2'd2) begin n_err++;
      $display("FAIL rti_nop got state %0d cnt %0d exp 0 2", b_state, b_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    ir = 16'hF025;
    tick(); tick();
    n_vec++; if (a_halt !== 1'b0 || strobes(a_c) !== 7'd0) begin n_err++;
      $display("FAIL halt_exec got halted %0b strobes %b exp 0 0000000", a_halt, strobes(a_c)); end
    for (int n = 0; n < 20; n++) begin
      tick();
      n_vec++; if (a_halt !== 1'b1 || a_state !== 3'd4 || strobes(a_c) !== 7'd0 || a_cnt !== 16'd1) begin n_err++;
        $display("FAIL halt_hold cyc %0d got halted %0b state %0d strobes %b cnt %0d exp 1 4 0000000 1",
                 n, a_halt, a_state, strobes(a_c), a_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_br();
    test_ldi();
    test_jsr();
    test_random();
    test_reset_mid();
    test_cnt_wrap();
    test_rsvd();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
